// File: rtl/input_debouncer_pkg.sv
// Shared defaults for the input debouncer: channel count, debounce length
// and the width of the optional rise[0] event counter.
package input_debouncer_pkg;

    localparam int DEF_WIDTH           = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int EVT_CNT_W           = 8;

    // Counter width able to hold the values 0..debounce_cycles
    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/input_debouncer_chan.sv
// One debounce channel: two-flop synchronizer, agreement counter, debounced
// level and registered single-cycle rise/fall pulses.
module debounce_chan
    import input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            dout <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            cnt  <= '0;
        end else begin
            // The synchronizer keeps running while the debounce state is frozen
            s1   <= din;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (ena) begin
                if (s2 == dout) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    dout <= s2;
                    cnt  <= '0;
                    rise <= s2;
                    fall <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// WIDTH independent debounce channels; defining INPUT_DEBOUNCER_EVENT_CNT_EN
// adds cnt_clr / evt_cnt, a wrapping count of rise[0] pulses.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic [WIDTH-1:0]     rise,
    output logic [WIDTH-1:0]     fall
`ifdef INPUT_DEBOUNCER_EVENT_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [EVT_CNT_W-1:0] evt_cnt
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .ena  (ena),
            .din  (din[i]),
            .dout (dout[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

`ifdef INPUT_DEBOUNCER_EVENT_CNT_EN
    // Clear wins over a coincident rise[0]; the count wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_cnt <= '0;
        end else if (cnt_clr) begin
            evt_cnt <= '0;
        end else if (rise[0]) begin
            evt_cnt <= evt_cnt + 1'b1;
        end
    end
`endif

endmodule
